// File: rtl/hilo_muldiv_sequencer_pkg.sv
// hilo_pkg: shared op/state encodings and defaults for the HI/LO mul/div sequencer
package hilo_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;
  typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} op_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_e;
  function automatic logic op_signed(input logic [1:0] op);
    return op == OP_MULT || op == OP_DIV;
  endfunction
endpackage

// File: rtl/hilo_muldiv_sequencer_if.sv
// hilo_muldiv_sequencer_if: EX-stage request and HI/LO write-back bundle
interface hilo_muldiv_sequencer_if import hilo_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
  logic start;
  logic [1:0] op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic hilo_read;
  logic flush;
  logic busy;
  logic stall;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic hilo_write;
  logic div_zero;
  modport master (
    output start, op, op_a, op_b, hilo_read, flush,
    input busy, stall, hi_out, lo_out, hilo_write, div_zero
  );
  modport slave (
    input start, op, op_a, op_b, hilo_read, flush,
    output busy, stall, hi_out, lo_out, hilo_write, div_zero
  );
endinterface

// File: rtl/hilo_muldiv_sequencer_iter.sv
// muldiv_iter_core: one radix-2 shift-add or restoring shift-subtract step per cycle on magnitudes
module muldiv_iter_core import hilo_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] low;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  assign sum     = rem + (low[0] ? {1'b0, b} : '0);
  assign shifted = {rem[WIDTH-1:0], low[WIDTH-1]};
  assign trial   = {1'b0, shifted} - {2'b0, b};
  assign hi      = rem[WIDTH-1:0];
  assign lo      = low;
  // upper half holds partial product / remainder, lower half multiplier bits / quotient bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem <= '0;
      low <= '0;
    end else if (load) begin
      rem <= '0;
      low <= a;
    end else if (step) begin
      rem <= div ? (trial[WIDTH+1] ? shifted : trial[WIDTH:0]) : {1'b0, sum[WIDTH:1]};
      low <= div ? {low[WIDTH-2:0], ~trial[WIDTH+1]} : {sum[0], low[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// hilo_muldiv_sequencer: multi-cycle MULT/MULTU/DIV/DIVU with HI/LO write strobe and pipeline stall
module hilo_muldiv_sequencer import hilo_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic rst,
  hilo_muldiv_sequencer_if.slave bus
);
  state_e             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic               accept, sa, sb;
  logic               is_div, neg_p, neg_r, dz;
  logic [WIDTH-1:0]   a_in, b_in, a_orig, b_mag;
  logic [WIDTH-1:0]   core_hi, core_lo, hi_r, lo_r, hi_n, lo_n, quo_f, rem_f;
  logic [2*WIDTH-1:0] prod, prod_f;
  assign sa     = op_signed(bus.op) & bus.op_a[WIDTH-1];
  assign sb     = op_signed(bus.op) & bus.op_b[WIDTH-1];
  assign a_in   = sa ? -bus.op_a : bus.op_a;
  assign b_in   = sb ? -bus.op_b : bus.op_b;
  assign accept = state == S_IDLE && bus.start && !bus.flush;
  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .step (state == S_RUN),
    .div  (is_div),
    .a    (a_in),
    .b    (b_mag),
    .hi   (core_hi),
    .lo   (core_lo)
  );
  assign prod   = {core_hi, core_lo};
  assign prod_f = neg_p ? -prod : prod;
  assign quo_f  = neg_p ? -core_lo : core_lo;
  assign rem_f  = neg_r ? -core_hi : core_hi;
  assign hi_n   = dz ? a_orig : is_div ? rem_f : prod_f[2*WIDTH-1:WIDTH];
  assign lo_n   = dz ? '1 : is_div ? quo_f : prod_f[WIDTH-1:0];
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else state <= state_n;
  end
  // next state and outputs; flush is ignored in DONE so a committed result always writes
  always_comb begin
    state_n        = state;
    bus.busy       = state != S_IDLE;
    bus.stall      = state != S_IDLE && (bus.start || bus.hilo_read);
    bus.hilo_write = state == S_DONE;
    bus.hi_out     = state == S_DONE ? hi_r : '0;
    bus.lo_out     = state == S_DONE ? lo_r : '0;
    bus.div_zero   = state == S_DONE && dz;
    unique case (state)
      S_IDLE:  state_n = accept ? S_RUN : S_IDLE;
      S_RUN:   state_n = bus.flush ? S_IDLE : cnt == CNT_W'(WIDTH - 1) ? S_FIX : S_RUN;
      S_FIX:   state_n = bus.flush ? S_IDLE : S_DONE;
      default: state_n = S_IDLE;
    endcase
  end
  // iteration counter, running only while in RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else cnt <= state == S_RUN ? cnt + 1'b1 : '0;
  end
  // operand magnitude, sign flags and divide-by-zero captured on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_div <= 1'b0;
      neg_p  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      a_orig <= '0;
      b_mag  <= '0;
    end else if (accept) begin
      is_div <= bus.op[1];
      neg_p  <= sa ^ sb;
      neg_r  <= sa;
      dz     <= bus.op[1] && bus.op_b == '0;
      a_orig <= bus.op_a;
      b_mag  <= b_in;
    end
  end
  // sign-corrected result captured in FIX, presented during DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (state == S_FIX) begin
      hi_r <= hi_n;
      lo_r <= lo_n;
    end
  end
endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// tb_hilo_muldiv_sequencer: directed self-checking bench for the HI/LO mul/div sequencer
module tb_hilo_muldiv_sequencer;
  import hilo_pkg::*;
  logic clk;
  logic rst;
  int total = 0;
  int bad = 0;
  int wc, bc, sc, wr;
  logic [31:0] hi, lo;
  logic dz;
  hilo_muldiv_sequencer_if #(.WIDTH(32)) bus ();
  hilo_muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic go(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op = op;
    bus.op_a = a;
    bus.op_b = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask
  task automatic wait_res(output int w, output int bcnt, output logic [31:0] h, output logic [31:0] l, output logic z);
    w = 0;
    bcnt = 0;
    h = '0;
    l = '0;
    z = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.busy) bcnt++;
      if (bus.hilo_write) begin
        w = k;
        h = bus.hi_out;
        l = bus.lo_out;
        z = bus.div_zero;
      end
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.hilo_read = 1'b0;
    bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_write", bus.hilo_write, 0);
    chk("rst_hi", bus.hi_out, 0);
    chk("rst_lo", bus.lo_out, 0);
    chk("rst_dz", bus.div_zero, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    go(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_res(wc, bc, hi, lo, dz);
    chk("multu_cycle", wc, 34);
    chk("multu_busy_cycles", bc, 34);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);
    chk("multu_dz", dz, 0);
    go(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_res(wc, bc, hi, lo, dz);
    chk("mult_cycle", wc, 34);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);
    go(OP_MULT, 32'h8000_0000, 32'h8000_0000);
    wait_res(wc, bc, hi, lo, dz);
    chk("mult_min_hi", hi, 32'h4000_0000);
    chk("mult_min_lo", lo, 32'h0000_0000);
    go(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_res(wc, bc, hi, lo, dz);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_dz", dz, 0);
    go(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_res(wc, bc, hi, lo, dz);
    chk("div_min_hi", hi, 32'h0000_0000);
    chk("div_min_lo", lo, 32'h8000_0000);
    go(OP_DIVU, 32'h1234_5678, 32'd0);
    wait_res(wc, bc, hi, lo, dz);
    chk("divz_cycle", wc, 34);
    chk("divz_hi", hi, 32'h1234_5678);
    chk("divz_lo", lo, 32'hFFFF_FFFF);
    chk("divz_dz", dz, 1);
    go(OP_DIV, 32'hFFFF_FFF0, 32'd0);
    wait_res(wc, bc, hi, lo, dz);
    chk("divz_s_hi", hi, 32'hFFFF_FFF0);
    chk("divz_s_dz", dz, 1);
    go(OP_MULTU, 32'd7, 32'd9);
    sc = 0;
    wc = 0;
    hi = '0;
    lo = '0;
    for (int k = 1; k <= 35; k++) begin
      if (k == 5) begin
        bus.start = 1'b1;
        bus.op = OP_DIVU;
        bus.op_a = 32'd100;
        bus.op_b = 32'd7;
        bus.hilo_read = 1'b1;
      end
      @(negedge clk);
      if (bus.stall) sc++;
      if (bus.hilo_write) begin
        wc = k;
        hi = bus.hi_out;
        lo = bus.lo_out;
      end
      if (k == 35) chk("stall_released", bus.stall, 0);
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    bus.hilo_read = 1'b0;
    chk("stall_cycles", sc, 30);
    chk("first_cycle", wc, 34);
    chk("first_hi", hi, 32'd0);
    chk("first_lo", lo, 32'd63);
    wait_res(wc, bc, hi, lo, dz);
    chk("second_cycle", wc, 34);
    chk("divu_hi", hi, 32'd2);
    chk("divu_lo", lo, 32'd14);
    go(OP_MULT, 32'd3, 32'd3);
    wr = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 10) bus.flush = 1'b1;
      if (k == 11) bus.flush = 1'b0;
      @(negedge clk);
      if (bus.hilo_write) wr++;
      if (k == 10) chk("flush_busy_before", bus.busy, 1);
      if (k == 11) chk("flush_busy_after", bus.busy, 0);
      @(posedge clk);
      #1;
    end
    chk("flush_writes", wr, 0);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_start", bus.busy, 0);
    @(posedge clk);
    #1;
    go(OP_MULTU, 32'd5, 32'd5);
    repeat (9) @(posedge clk);
    #1 bus.hilo_read = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy_before", bus.busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_stall", bus.stall, 0);
    chk("rst_mid_write", bus.hilo_write, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.hilo_read = 1'b0;
    wr = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.hilo_write || bus.busy) wr++;
      @(posedge clk);
      #1;
    end
    chk("rst_mid_activity", wr, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
